// File: rtl/fpu_fma_wb_pkg.sv
// Shared FPU constants for the FMA result collector: recoded-float width, exception flag layout, tag default.
package fpu_fma_wb_pkg;

    localparam int unsigned REC_W     = 33;
    localparam int unsigned EXC_W     = 5;
    localparam int unsigned TAG_W_DEF = 5;

    // Exception flag bit positions, MSB to LSB: NV, DZ, OF, UF, NX
    localparam int unsigned EXC_NV = 4;
    localparam int unsigned EXC_DZ = 3;
    localparam int unsigned EXC_OF = 2;
    localparam int unsigned EXC_UF = 1;
    localparam int unsigned EXC_NX = 0;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module fpu_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    a_no_pop_empty: assert property (@(posedge clock) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/fpu_fma_wb.sv
// FMA result collector: tracks issued tags through the pipe latency, buffers results, credits issue.
// Optional sticky exception accumulator enabled by FPU_FMA_WB_FFLAGS_ACCUM_EN.
module fpu_fma_wb
    import fpu_fma_wb_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = TAG_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_issue_valid,
    input  logic [TAG_W-1:0] io_issue_tag,
    output logic             io_issue_ready,
    input  logic [REC_W-1:0] io_fma_data,
    input  logic [EXC_W-1:0] io_fma_exc,
    output logic             io_wb_valid,
    input  logic             io_wb_ready,
    output logic [TAG_W-1:0] io_wb_tag,
    output logic [REC_W-1:0] io_wb_data,
    output logic [EXC_W-1:0] io_wb_exc,
    output logic             io_busy,
    input  logic             io_fflags_clear,
    output logic [EXC_W-1:0] io_fflags_accum
);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = TAG_W + REC_W + EXC_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [REC_W-1:0] data;
        fflags_t          exc;
    } wb_entry_t;

    logic [LATENCY-1:0] sr_valid;
    logic [TAG_W-1:0]   sr_tag [LATENCY];
    logic [CNT_W-1:0]   count;
    logic               issue_fire;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    wb_entry_t          push_entry;
    wb_entry_t          head;

    assign issue_fire = io_issue_valid & io_issue_ready;
    assign pop        = io_wb_valid & io_wb_ready;
    assign push       = sr_valid[LATENCY-1];

    // Tag pipe mirrors the FMA pipe, which never stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr_valid <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                sr_tag[i] <= '0;
            end
        end else begin
            sr_valid[0] <= issue_fire;
            sr_tag[0]   <= io_issue_tag;
            for (int i = 1; i < int'(LATENCY); i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_tag[i]   <= sr_tag[i-1];
            end
        end
    end

    // Credits cover both in-flight and queued results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            unique case ({issue_fire, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.tag  = sr_tag[LATENCY-1];
        push_entry.data = io_fma_data;
        push_entry.exc  = fflags_t'(io_fma_exc);
    end

    fpu_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign io_issue_ready = (count < CNT_W'(DEPTH));
    assign io_busy        = (count != '0);
    assign io_wb_valid    = ~fifo_empty;
    assign io_wb_tag      = head.tag;
    assign io_wb_data     = head.data;
    assign io_wb_exc      = head.exc;

`ifdef FPU_FMA_WB_FFLAGS_ACCUM_EN
    logic [EXC_W-1:0] fflags_q;

    // Clear takes priority over a same-edge pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fflags_q <= '0;
        end else if (io_fflags_clear) begin
            fflags_q <= '0;
        end else if (pop) begin
            fflags_q <= fflags_q | io_wb_exc;
        end
    end

    assign io_fflags_accum = fflags_q;
`else
    logic unused_fflags_clear;
    assign unused_fflags_clear = io_fflags_clear;
    assign io_fflags_accum     = '0;
`endif

    a_no_issue_when_full: assert property (@(posedge clock) disable iff (reset)
        !(io_issue_valid && !io_issue_ready));
    a_no_push_into_full: assert property (@(posedge clock) disable iff (reset)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fpu_fma_wb.sv
// Self-checking bench for fpu_fma_wb: queue-based reference model, vector table and corner sequences.
module tb_fpu_fma_wb;
    localparam int L = 3;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_issue_valid;
    logic [4:0]  io_issue_tag;
    logic        io_issue_ready;
    logic [32:0] io_fma_data;
    logic [4:0]  io_fma_exc;
    logic        io_wb_valid;
    logic        io_wb_ready;
    logic [4:0]  io_wb_tag;
    logic [32:0] io_wb_data;
    logic [4:0]  io_wb_exc;
    logic        io_busy;
    logic        io_fflags_clear;
    logic [4:0]  io_fflags_accum;

    fpu_fma_wb #(.LATENCY(L), .DEPTH(D), .TAG_W(5)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_issue_valid  (io_issue_valid),
        .io_issue_tag    (io_issue_tag),
        .io_issue_ready  (io_issue_ready),
        .io_fma_data     (io_fma_data),
        .io_fma_exc      (io_fma_exc),
        .io_wb_valid     (io_wb_valid),
        .io_wb_ready     (io_wb_ready),
        .io_wb_tag       (io_wb_tag),
        .io_wb_data      (io_wb_data),
        .io_wb_exc       (io_wb_exc),
        .io_busy         (io_busy),
        .io_fflags_clear (io_fflags_clear),
        .io_fflags_accum (io_fflags_accum)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  tag;
        logic [32:0] data;
        logic [4:0]  exc;
        int          due;
    } op_t;

    typedef struct {
        logic [4:0]  tag;
        logic [32:0] data;
        logic [4:0]  exc;
        logic [4:0]  exp_tag;
        logic [32:0] exp_data;
        logic [4:0]  exp_exc;
        int          exp_lat;
    } vec_t;

    op_t         inflight[$];
    op_t         fq[$];
    logic [32:0] ring_d[16];
    logic [4:0]  ring_e[16];
    logic [4:0]  acc;
    int          t;
    int          n_checks;
    int          n_pass;
    int          n_popped;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    endtask

    function automatic int model_cnt();
        return inflight.size() + fq.size();
    endfunction

    task automatic check_outputs();
        logic ev;
        ev = (fq.size() != 0);
        chk("wb_valid", 64'(io_wb_valid), 64'(ev));
        if (ev) begin
            chk("wb_tag", 64'(io_wb_tag), 64'(fq[0].tag));
            chk("wb_data", 64'(io_wb_data), 64'(fq[0].data));
            chk("wb_exc", 64'(io_wb_exc), 64'(fq[0].exc));
        end
        chk("issue_ready", 64'(io_issue_ready), 64'(model_cnt() < D));
        chk("busy", 64'(io_busy), 64'(model_cnt() != 0));
        chk("fflags_accum", 64'(io_fflags_accum), 64'(acc));
    endtask

    // One clock: check outputs, drive inputs, advance the reference model at the edge.
    task automatic cycle(input logic iv, input logic [4:0] itag, input logic [32:0] idata,
                         input logic [4:0] iexc, input logic rdy, input logic clr);
        logic popped;
        op_t  e;
        check_outputs();
        if (iv && model_cnt() >= D) iv = 1'b0;
        io_issue_valid  = iv;
        io_issue_tag    = itag;
        io_wb_ready     = rdy;
        io_fflags_clear = clr;
        ring_d[(t + L) % 16] = iv ? idata : {1'($urandom), 32'($urandom)};
        ring_e[(t + L) % 16] = iv ? iexc : 5'($urandom);
        io_fma_data = ring_d[t % 16];
        io_fma_exc  = ring_e[t % 16];
        @(posedge clock);
        popped = (fq.size() != 0) && rdy;
        if (popped) begin
            e = fq.pop_front();
            n_popped++;
        end
`ifdef FPU_FMA_WB_FFLAGS_ACCUM_EN
        if (clr) acc = 5'h0;
        else if (popped) acc = acc | e.exc;
`else
        acc = 5'h0;
`endif
        if (inflight.size() != 0 && inflight[0].due == t) fq.push_back(inflight.pop_front());
        if (iv) inflight.push_back('{tag: itag, data: idata, exc: iexc, due: t + L});
        t++;
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'h0, 33'h0, 5'h0, rdy, 1'b0);
    endtask

    task automatic issue(input logic [4:0] tag, input logic [32:0] data, input logic [4:0] exc, input logic rdy);
        cycle(1'b1, tag, data, exc, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && model_cnt() != 0; i++) idle(1, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tagname);
        chk({tagname, "_ready"}, 64'(io_issue_ready), 64'(1));
        chk({tagname, "_wb_valid"}, 64'(io_wb_valid), 64'(0));
        chk({tagname, "_wb_tag"}, 64'(io_wb_tag), 64'(0));
        chk({tagname, "_wb_data"}, 64'(io_wb_data), 64'(0));
        chk({tagname, "_wb_exc"}, 64'(io_wb_exc), 64'(0));
        chk({tagname, "_busy"}, 64'(io_busy), 64'(0));
        chk({tagname, "_accum"}, 64'(io_fflags_accum), 64'(0));
    endtask

    vec_t vecs[5];

    initial begin
        int lat;
        int issued;
        n_checks = 0; n_pass = 0; n_popped = 0; t = 0; acc = 5'h0;
        for (int i = 0; i < 16; i++) begin ring_d[i] = '0; ring_e[i] = '0; end
        vecs[0] = '{5'd5,  33'h0_3F800000, 5'h00, 5'd5,  33'h0_3F800000, 5'h00, L + 1};
        vecs[1] = '{5'd31, 33'h1_FFFFFFFF, 5'h1F, 5'd31, 33'h1_FFFFFFFF, 5'h1F, L + 1};
        vecs[2] = '{5'd0,  33'h0_00000000, 5'h10, 5'd0,  33'h0_00000000, 5'h10, L + 1};
        vecs[3] = '{5'd17, 33'h1_40490FDB, 5'h01, 5'd17, 33'h1_40490FDB, 5'h01, L + 1};
        vecs[4] = '{5'd10, 33'h0_AAAA5555, 5'h0A, 5'd10, 33'h0_AAAA5555, 5'h0A, L + 1};

        reset = 1'b1;
        io_issue_valid = 0; io_issue_tag = 0; io_fma_data = 0; io_fma_exc = 0;
        io_wb_ready = 0; io_fflags_clear = 0;
        repeat (3) @(negedge clock);
        check_reset_outputs("init");
        reset = 1'b0;

        // Single-op vectors: latency, payload, one-cycle valid, busy returns low.
        foreach (vecs[k]) begin
            issue(vecs[k].tag, vecs[k].data, vecs[k].exc, 1'b0);
            lat = 1;
            while (!io_wb_valid && lat < 20) begin idle(1, 1'b0); lat++; end
            chk("vec_latency", 64'(lat), 64'(vecs[k].exp_lat));
            chk("vec_tag", 64'(io_wb_tag), 64'(vecs[k].exp_tag));
            chk("vec_data", 64'(io_wb_data), 64'(vecs[k].exp_data));
            chk("vec_exc", 64'(io_wb_exc), 64'(vecs[k].exp_exc));
            idle(1, 1'b1);
            chk("vec_valid_one_cycle", 64'(io_wb_valid), 64'(0));
            chk("vec_busy_low", 64'(io_busy), 64'(0));
        end

        // Credit stall: four accepted issues close the credit window.
        for (int k = 1; k <= 4; k++) issue(5'(k), 33'(k * 3 + 1), 5'(k), 1'b0);
        chk("stall_ready_low", 64'(io_issue_ready), 64'(0));
        idle(L, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            chk("stall_order_tag", 64'(io_wb_tag), 64'(k));
            idle(1, 1'b1);
        end
        chk("stall_ready_back", 64'(io_issue_ready), 64'(1));

        // Full FIFO: lone pop frees a credit; issue+pop holds count; issue refills.
        for (int k = 6; k <= 9; k++) issue(5'(k), 33'(k), 5'h0, 1'b0);
        idle(L + 1, 1'b0);
        chk("full_ready_low", 64'(io_issue_ready), 64'(0));
        idle(1, 1'b1);
        chk("after_pop_ready", 64'(io_issue_ready), 64'(1));
        issue(5'd10, 33'h10, 5'h0, 1'b1);
        chk("issue_pop_ready", 64'(io_issue_ready), 64'(1));
        issue(5'd11, 33'h11, 5'h0, 1'b0);
        chk("refill_ready_low", 64'(io_issue_ready), 64'(0));
        drain();

        // Pointer wrap: 20 ops with random writeback ready.
        n_popped = 0; issued = 0;
        for (int c = 0; c < 400 && n_popped < 20; c++) begin
            logic iv;
            iv = (issued < 20) && ($urandom_range(0, 3) != 0) && (model_cnt() < D);
            if (iv) issued++;
            cycle(iv, 5'($urandom), {1'($urandom), 32'($urandom)}, 5'($urandom),
                  1'($urandom_range(0, 1)), 1'b0);
        end
        chk("wrap_count", 64'(n_popped), 64'(20));

        // Reset with one queued and two in flight.
        issue(5'd21, 33'h21, 5'h0, 1'b0);
        idle(L, 1'b0);
        issue(5'd22, 33'h22, 5'h0, 1'b0);
        issue(5'd23, 33'h23, 5'h0, 1'b0);
        chk("pre_reset_busy", 64'(io_busy), 64'(1));
        reset = 1'b1;
        io_issue_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        inflight.delete(); fq.delete(); acc = 5'h0;
        @(posedge clock); t++;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < L + 3; i++) begin
            chk("no_stale", 64'(io_wb_valid), 64'(0));
            idle(1, 1'b1);
        end

        // Sticky exception accumulator.
        idle(1, 1'b0);
        cycle(1'b0, 5'h0, 33'h0, 5'h0, 1'b0, 1'b1);
        issue(5'd1, 33'h1, 5'h01, 1'b0);
        issue(5'd2, 33'h2, 5'h10, 1'b0);
        idle(L, 1'b0);
        idle(2, 1'b1);
`ifdef FPU_FMA_WB_FFLAGS_ACCUM_EN
        chk("accum_or", 64'(io_fflags_accum), 64'(5'h11));
`else
        chk("accum_tied", 64'(io_fflags_accum), 64'(5'h00));
`endif
        issue(5'd3, 33'h3, 5'h04, 1'b0);
        idle(L, 1'b0);
        cycle(1'b0, 5'h0, 33'h0, 5'h0, 1'b1, 1'b1);
        chk("accum_clear_wins", 64'(io_fflags_accum), 64'(5'h00));

        // Random soak against the model.
        for (int c = 0; c < 600; c++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom), {1'($urandom), 32'($urandom)},
                  5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        drain();
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
